// File: rtl/press_classifier_pkg.sv
// Shared types and sizing helpers for the press classifier.
package press_classifier_pkg;

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        PRESS1   = 2'd2,
        GAP      = 2'd3
    } press_state_e;

    // The timer has to hold the larger of the two thresholds.
    function automatic int timer_width(input int long_cycles, input int gap_cycles);
        int max_cycles;
        max_cycles = (long_cycles > gap_cycles) ? long_cycles : gap_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/press_timer.sv
// Saturating up-counter with synchronous clear and count enable.
module press_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_base;

    // Clear and enable together load 1, so the current sample is counted.
    always_comb begin
        cnt_base = clr_i ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (en_i && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced switch gestures into short, long and double presses,
// emitting one-cycle pulses and a wrapping event count.
//
// state    | meaning
// ---------+----------------------------------------------------------
// WAIT_REL | ignore the switch until a low sample is seen
// IDLE     | released, waiting for the first rise of a gesture
// PRESS1   | first press held, timer counts high samples
// GAP      | first press released, timer counts low samples
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int LONG_CYCLES = 1000,
    parameter int GAP_CYCLES  = 300,
    parameter int EVT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             db_level_i,
    output logic             pressed_o,
    output logic             short_o,
    output logic             long_o,
    output logic             double_o,
    output logic [EVT_W-1:0] event_count_o
);

    localparam int TMR_W = timer_width(LONG_CYCLES, GAP_CYCLES);
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LIM   = TMR_W'(GAP_CYCLES);

    press_state_e     state_q, state_d;
    logic             lvl_q, lvl_d;
    logic             lvl_prev_q, lvl_prev_d;
    logic             smp_vld_q, smp_vld_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic [TMR_W-1:0] tmr_cnt;
    logic             tmr_clr;
    logic             tmr_en;
    logic             rise;
    logic             pulse;

    press_timer #(
        .W(TMR_W)
    ) u_press_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .cnt_o (tmr_cnt)
    );

    // lvl_q right after reset is the reset value, not a real sample, so the
    // FSM waits one cycle; otherwise a switch held through reset would look
    // like a release followed by a fresh rise.
    always_comb begin
        lvl_d      = db_level_i;
        lvl_prev_d = lvl_q;
        smp_vld_d  = 1'b1;
    end

    assign rise = lvl_q & ~lvl_prev_q;

    always_comb begin
        state_d  = state_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        if (smp_vld_q) begin
            case (state_q)
                WAIT_REL: begin
                    if (!lvl_q) begin
                        state_d = IDLE;
                        tmr_clr = 1'b1;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        state_d = PRESS1;
                        tmr_clr = 1'b1;
                        tmr_en  = 1'b1;
                    end
                end
                PRESS1: begin
                    if (lvl_q) begin
                        if (tmr_cnt == LONG_LAST) begin
                            long_d  = 1'b1;
                            state_d = WAIT_REL;
                            tmr_clr = 1'b1;
                        end else begin
                            tmr_en = 1'b1;
                        end
                    end else begin
                        state_d = GAP;
                        tmr_clr = 1'b1;
                        tmr_en  = 1'b1;
                    end
                end
                GAP: begin
                    if (rise) begin
                        if (tmr_cnt < GAP_LIM) begin
                            double_d = 1'b1;
                            state_d  = WAIT_REL;
                            tmr_clr  = 1'b1;
                        end
                    end else if (!lvl_q) begin
                        if (tmr_cnt == GAP_LAST) begin
                            short_d = 1'b1;
                            state_d = IDLE;
                            tmr_clr = 1'b1;
                        end else begin
                            tmr_en = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = WAIT_REL;
                    tmr_clr = 1'b1;
                end
            endcase
        end
    end

    assign pulse = short_d | long_d | double_d;

    always_comb begin
        evt_cnt_d = evt_cnt_q + {{(EVT_W-1){1'b0}}, pulse};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= WAIT_REL;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            smp_vld_q  <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            double_q   <= 1'b0;
            evt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
            smp_vld_q  <= smp_vld_d;
            short_q    <= short_d;
            long_q     <= long_d;
            double_q   <= double_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign pressed_o     = lvl_q;
    assign short_o       = short_q;
    assign long_o        = long_q;
    assign double_o      = double_q;
    assign event_count_o = evt_cnt_q;

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier: stimulus is a list of level runs,
// expectations come from a run-length gesture model.
module tb_press_classifier;

    localparam int LONG_CYCLES = 20;
    localparam int GAP_CYCLES  = 8;
    localparam int EVT_W       = 8;

    localparam int EV_NONE   = 0;
    localparam int EV_SHORT  = 1;
    localparam int EV_LONG   = 2;
    localparam int EV_DOUBLE = 3;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             db_level_i = 1'b0;
    logic             pressed_o;
    logic             short_o;
    logic             long_o;
    logic             double_o;
    logic [EVT_W-1:0] event_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    int run_len[$];
    bit run_lvl[$];
    bit exp_lvl[$];
    int exp_evt[$];

    press_classifier #(
        .LONG_CYCLES (LONG_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .EVT_W       (EVT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .db_level_i    (db_level_i),
        .pressed_o     (pressed_o),
        .short_o       (short_o),
        .long_o        (long_o),
        .double_o      (double_o),
        .event_count_o (event_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [2:0] pulse_vec(input int ev);
        logic [2:0] v;
        v = 3'b000;
        if (ev == EV_SHORT)  v = 3'b100;
        if (ev == EV_LONG)   v = 3'b010;
        if (ev == EV_DOUBLE) v = 3'b001;
        return v;
    endfunction

    task automatic clear_runs();
        run_len.delete();
        run_lvl.delete();
    endtask

    task automatic add_run(input bit lvl, input int len);
        run_lvl.push_back(lvl);
        run_len.push_back(len);
    endtask

    // Gesture model over alternating runs, starting from reset (switch not
    // yet seen released). exp_evt[s] is the event decided by sample s.
    task automatic build_model();
        int  t;
        bit  armed;
        bit  pending;
        int  gap_so_far;
        exp_lvl.delete();
        exp_evt.delete();
        for (int r = 0; r < run_len.size(); r++) begin
            for (int i = 0; i < run_len[r]; i++) begin
                exp_lvl.push_back(run_lvl[r]);
                exp_evt.push_back(EV_NONE);
            end
        end
        t = 0;
        armed = 1'b0;
        pending = 1'b0;
        gap_so_far = 0;
        for (int r = 0; r < run_len.size(); r++) begin
            if (run_lvl[r]) begin
                if (armed && pending) begin
                    exp_evt[t] = EV_DOUBLE;
                    armed = 1'b0;
                    pending = 1'b0;
                end else if (armed) begin
                    if (run_len[r] >= LONG_CYCLES) begin
                        exp_evt[t + LONG_CYCLES - 1] = EV_LONG;
                        armed = 1'b0;
                    end else begin
                        pending = 1'b1;
                        gap_so_far = 0;
                    end
                end
            end else begin
                if (!armed) begin
                    armed = 1'b1;
                end else if (pending) begin
                    if (gap_so_far + run_len[r] >= GAP_CYCLES) begin
                        exp_evt[t + GAP_CYCLES - gap_so_far - 1] = EV_SHORT;
                        pending = 1'b0;
                    end else begin
                        gap_so_far += run_len[r];
                    end
                end
            end
            t += run_len[r];
        end
    endtask

    // Called at a negedge with reset just released (or still asserted by the
    // caller's do_reset). Drives every sample plus one trailing low sample.
    task automatic play(input string name);
        int n;
        int cnt;
        int ev;
        bit lvl;
        build_model();
        n = exp_lvl.size();
        cnt = 0;
        for (int k = 0; k <= n; k++) begin
            lvl = (k < n) ? exp_lvl[k] : 1'b0;
            db_level_i = lvl;
            @(posedge clk_i);
            @(negedge clk_i);
            ev = (k >= 1) ? exp_evt[k-1] : EV_NONE;
            if (ev != EV_NONE) cnt++;
            n_checks++;
            if ({short_o, long_o, double_o} !== pulse_vec(ev)) begin
                n_fail++;
                $display("FAIL %s pulses cycle %0d: got {s,l,d}=%b expected %b",
                         name, k, {short_o, long_o, double_o}, pulse_vec(ev));
            end
            n_checks++;
            if ($countones({short_o, long_o, double_o}) > 1) begin
                n_fail++;
                $display("FAIL %s exclusive cycle %0d: got %b expected at most one set",
                         name, k, {short_o, long_o, double_o});
            end
            n_checks++;
            if (event_count_o !== EVT_W'(cnt)) begin
                n_fail++;
                $display("FAIL %s event_count cycle %0d: got %0d expected %0d",
                         name, k, event_count_o, cnt % 256);
            end
            n_checks++;
            if (pressed_o !== lvl) begin
                n_fail++;
                $display("FAIL %s pressed cycle %0d: got %b expected %b",
                         name, k, pressed_o, lvl);
            end
        end
    endtask

    // Entered at a negedge; asserts reset for 'cycles' edges, checks that all
    // outputs are zero, releases reset at the following negedge.
    task automatic do_reset(input bit lvl, input int cycles);
        rst_i = 1'b1;
        db_level_i = lvl;
        repeat (cycles) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({pressed_o, short_o, long_o, double_o, event_count_o} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got p=%b s=%b l=%b d=%b cnt=%0d expected all 0",
                     pressed_o, short_o, long_o, double_o, event_count_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic check_count(input string name, input int expected);
        n_checks++;
        if (event_count_o !== EVT_W'(expected)) begin
            n_fail++;
            $display("FAIL %s final count: got %0d expected %0d", name, event_count_o, expected);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1, 3);
        clear_runs();
        add_run(1'b1, 5);
        add_run(1'b0, 3);
        add_run(1'b1, 5);
        add_run(1'b0, 8);
        play("reset_held");
        check_count("reset_held", 1);
    endtask

    task automatic test_long_press();
        do_reset(1'b0, 2);
        clear_runs();
        add_run(1'b0, 2);
        add_run(1'b1, 40);
        add_run(1'b0, 10);
        play("long_press");
        check_count("long_press", 1);
    endtask

    task automatic test_double_press();
        do_reset(1'b0, 2);
        clear_runs();
        add_run(1'b0, 2);
        add_run(1'b1, 5);
        add_run(1'b0, 7);
        add_run(1'b1, 5);
        add_run(1'b0, 10);
        play("double_press");
        check_count("double_press", 1);
    endtask

    task automatic test_gap_boundary();
        do_reset(1'b0, 2);
        clear_runs();
        add_run(1'b0, 2);
        add_run(1'b1, 5);
        add_run(1'b0, 8);
        add_run(1'b1, 5);
        add_run(1'b0, 8);
        play("gap_boundary");
        check_count("gap_boundary", 2);
    endtask

    task automatic test_reset_mid_gesture();
        do_reset(1'b0, 2);
        clear_runs();
        add_run(1'b0, 2);
        add_run(1'b1, 5);
        add_run(1'b0, 4);
        play("mid_gesture_pre");
        do_reset(1'b0, 1);
        clear_runs();
        add_run(1'b0, 20);
        play("mid_gesture_post");
        check_count("mid_gesture", 0);
    endtask

    task automatic test_random();
        do_reset(1'b0, 2);
        clear_runs();
        add_run(1'b0, 2);
        for (int i = 0; i < 150; i++) begin
            add_run(1'b1, int'($urandom_range(1, 28)));
            add_run(1'b0, int'($urandom_range(1, 12)));
        end
        play("random");
    endtask

    task automatic test_counter_wrap();
        do_reset(1'b0, 2);
        clear_runs();
        add_run(1'b0, 2);
        for (int i = 0; i < 256; i++) begin
            add_run(1'b1, int'($urandom_range(1, LONG_CYCLES - 1)));
            add_run(1'b0, int'($urandom_range(GAP_CYCLES, GAP_CYCLES + 3)));
        end
        play("counter_wrap");
        check_count("counter_wrap", 0);
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_long_press();
        test_double_press();
        test_gap_boundary();
        test_reset_mid_gesture();
        test_random();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/press_classifier.md
# press_classifier

Downstream consumer of the switch debouncer. It takes the debounced switch level and classifies each user gesture as a short press, a long press or a double press. For each gesture it emits a one-cycle pulse and keeps a wrapping count of emitted events. The block sits between the debouncer and the application control logic, and assumes its input is already bounce-free.

## Interface
- `LONG_CYCLES`, default 1000: consecutive high samples that make a press "long"; legal range ≥ 2.
- `GAP_CYCLES`, default 300: low-sample window after a short release in which a second press counts as "double"; legal range ≥ 2.
- `EVT_W`, default 8: width of the event counter.
- `clk_i` input 1: single clock; all state changes on its rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `db_level_i` input 1: debounced switch level from the debouncer (1 = pressed).
- `pressed_o` output 1: registered copy of `db_level_i`.
- `short_o` output 1: one-cycle pulse, short press recognised.
- `long_o` output 1: one-cycle pulse, long press recognised.
- `double_o` output 1: one-cycle pulse, double press recognised.
- `event_count_o` output EVT_W: number of pulses emitted on `short_o`, `long_o` and `double_o` combined, modulo 2^EVT_W.

## Operation
- **Input stage.** `db_level_i` is registered into `lvl_q` and `lvl_q` is the only level the FSM sees. A rise is `lvl_q` = 1 in the current sample after 0 in the previous sample.
- **Timer.** A single timer counts consecutive samples.
  - Width is $clog2(max(LONG_CYCLES, GAP_CYCLES)+1).
  - It clears on every state change and saturates at its maximum value; it never wraps.
- **FSM states:** `WAIT_REL`, `IDLE`, `PRESS1`, `GAP`.
  - `WAIT_REL`: on a low sample, go to `IDLE`. Nothing else is acted on here.
  - `IDLE`: on a rise, go to `PRESS1`. The timer counts this first high sample as 1.
  - `PRESS1`, high sample: the timer increments. When the timer reaches `LONG_CYCLES`, fire `long_o` and go to `WAIT_REL`.
  - `PRESS1`, low sample: go to `GAP`. The timer counts this first low sample as 1.
  - `GAP`, rise with timer < `GAP_CYCLES` (i.e. at most `GAP_CYCLES`-1 low samples so far): fire `double_o` and go to `WAIT_REL`.
  - `GAP`, low sample: the timer increments. When it reaches `GAP_CYCLES`, fire `short_o` and go to `IDLE`.
- **Pulse exclusivity.** At most one of `short_o`, `long_o`, `double_o` is high in any cycle. `event_count_o` increments in the same cycle as each pulse.
- **Second press.** A second press that is held long after `double_o` produces no `long_o`: the FSM is in `WAIT_REL`.
- **Gap boundary.** `GAP_CYCLES`-1 low samples followed by a rise gives `double_o`. Exactly `GAP_CYCLES` low samples give `short_o`, and a following rise starts a fresh gesture from `IDLE`.
- **Reset.**
  - The FSM goes to `WAIT_REL`, so a switch already held at reset release is ignored until it is released.
  - `lvl_q`, the timer and all outputs go to 0, including `event_count_o`.
  - A reset during `PRESS1` or `GAP` discards the pending gesture; no pulse is emitted.

## Timing
- All outputs are registered.
- A decision based on the level sampled at clock edge e appears on the outputs from edge e+2 for exactly one cycle: one cycle for the input register, one for the output register.
- `pressed_o` follows `db_level_i` with 1 cycle latency.
- **`long_o`:** asserted 2 cycles after the edge that samples the `LONG_CYCLES`-th consecutive high level.
- **`short_o`:** asserted 2 cycles after the edge that samples the `GAP_CYCLES`-th consecutive low level following a press shorter than `LONG_CYCLES`.
- **`double_o`:** asserted 2 cycles after the edge that samples the second rising level.
- The block has no backpressure. Pulses are fire-and-forget, and the consumer must sample every cycle.

## Structure
- `press_classifier_pkg` holds:
  - the state enum `press_state_e` (`WAIT_REL`, `IDLE`, `PRESS1`, `GAP`);
  - a function computing the timer width from `LONG_CYCLES` and `GAP_CYCLES`.
- One sub-module, `press_timer`: a parameterised saturating counter with synchronous clear and enable. The FSM, the edge detection and the output registers stay in `press_classifier`.

## Test plan
The bench uses `LONG_CYCLES`=20, `GAP_CYCLES`=8, `EVT_W`=8.
1. **Reset held, switch high:** reset with `db_level_i`=1 held for 5 cycles after reset release, then 3 low, then 5 high, then 8 low. Required: no pulse from the first high period; exactly one `short_o`, 2 cycles after the 8th low sample; `event_count_o`=1.
2. **Long press:** hold 40 high samples, then 10 low. Required: `long_o` exactly once, 2 cycles after the 20th high sample; no `short_o` or `double_o`; `event_count_o`=1.
3. **Double press:** 5 high, 7 low, 5 high, 10 low. Required: `double_o` 2 cycles after the second rise; no `short_o` afterwards; `event_count_o`=1.
4. **Gap boundary:** 5 high, 8 low, 5 high, 8 low. Required: two `short_o` pulses and no `double_o`; `event_count_o`=2.
5. **Reset mid-gesture:** 5 high, 4 low, then `rst_i` for 1 cycle, then 20 low. Required: no pulses; all outputs 0 one cycle after reset.
6. **Counter wrap:** 256 short presses. Required: `event_count_o` returns to 0; never more than one pulse in a cycle.
